// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: sequences one multiply or divide at a time for the execute
// stage. It latches operands, launches the external multiplier or divider,
// stalls the pipeline while the operation runs, captures the result into
// the HI/LO registers, and commits it through a single-cycle DONE state.
// The multiplier product is taken on the closing edge of the MUL_LAT-th
// MUL cycle (the cycle in which the down-counter reaches 0).
module muldiv_ctrl #(
  parameter int MUL_LAT = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        flush,
  input  logic        op_start,
  input  logic        op_div,
  input  logic        op_sign,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        stall_req,
  output logic        busy,
  output logic        div_start,
  output logic        div_annul,
  output logic        div_signed,
  output logic [31:0] div_opa,
  output logic [31:0] div_opb,
  input  logic        div_ready,
  input  logic [63:0] div_result,
  output logic        mul_start,
  output logic        mul_signed,
  output logic [31:0] mul_opa,
  output logic [31:0] mul_opb,
  input  logic [63:0] mul_result,
  output logic        hilo_we,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  localparam logic [3:0] CNT_INIT = 4'(MUL_LAT - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        commit_q, commit_d;
  logic        sign_q;
  logic [31:0] opa_q, opb_q, hi_q, lo_q;
  logic        latch, cap_mul, cap_div;

  // State, latency counter and commit flag
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      commit_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      commit_q <= commit_d;
    end
  end

  // Next state, strobes and stall; op_start is only looked at in IDLE
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    commit_d  = commit_q;
    latch     = 1'b0;
    cap_mul   = 1'b0;
    cap_div   = 1'b0;
    stall_req = 1'b0;
    div_start = 1'b0;
    div_annul = 1'b0;
    mul_start = 1'b0;
    hilo_we   = 1'b0;
    case (state_q)
      IDLE: begin
        if (op_start && !flush) begin
          stall_req = 1'b1;
          latch     = 1'b1;
          if (!op_div) begin
            state_d = MUL;
            cnt_d   = CNT_INIT;
          end else if (src_b != '0) begin
            state_d = DIV;
          end else begin
            // divide by zero: pass through DONE without committing
            state_d  = DONE;
            commit_d = 1'b0;
          end
        end
      end
      MUL: begin
        stall_req = 1'b1;
        mul_start = (cnt_q == CNT_INIT);
        if (flush) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          cap_mul  = 1'b1;
          commit_d = 1'b1;
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DIV: begin
        stall_req = 1'b1;
        div_start = 1'b1;
        // flush wins over a same-cycle div_ready
        if (flush) begin
          div_annul = 1'b1;
          state_d   = IDLE;
        end else if (div_ready) begin
          cap_div  = 1'b1;
          commit_d = 1'b1;
          state_d  = DONE;
        end
      end
      DONE: begin
        hilo_we  = commit_q & ~flush;
        commit_d = 1'b0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // state is already IDLE under reset; only the op_start path needs masking
    if (!resetn) stall_req = 1'b0;
  end

  // Operand latch and HI/LO result registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sign_q <= 1'b0;
      opa_q  <= '0;
      opb_q  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      if (latch) begin
        sign_q <= op_sign;
        opa_q  <= src_a;
        opb_q  <= src_b;
      end
      if (cap_mul) begin
        hi_q <= mul_result[63:32];
        lo_q <= mul_result[31:0];
      end else if (cap_div) begin
        hi_q <= div_result[63:32];
        lo_q <= div_result[31:0];
      end
    end
  end

  assign busy       = (state_q != IDLE);
  assign div_signed = sign_q;
  assign mul_signed = sign_q;
  assign div_opa    = opa_q;
  assign div_opb    = opb_q;
  assign mul_opa    = opa_q;
  assign mul_opb    = opb_q;
  assign hi_out     = hi_q;
  assign lo_out     = lo_q;

endmodule
